// File: rtl/vedic_pp_accum.sv
// Accumulates four 4x4 Vedic partial products into a 16-bit product.
// A single 8-bit carry-lookahead adder is time-shared across three add states.

module vedic_cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] w_g, w_p;
  logic [8:0] w_c;
  logic       w_cc, w_pp;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is the flat OR of generate terms gated by downstream propagates.
  always_comb begin
    w_c    = '0;
    w_cc   = 1'b0;
    w_pp   = 1'b1;
    w_c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      w_cc = 1'b0;
      w_pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        w_cc = w_cc | (w_pp & w_g[j]);
        w_pp = w_pp & w_p[j];
      end
      w_c[i+1] = w_cc | (w_pp & cin);
    end
  end

  assign sum  = w_p ^ w_c[7:0];
  assign cout = w_c[8];
endmodule

module vedic_pp_accum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  q0,
  input  logic [7:0]  q1,
  input  logic [7:0]  q2,
  input  logic [7:0]  q3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        ovf
);
  typedef enum logic [2:0] {S_IDLE, S_ADD1, S_ADD2, S_ADD3, S_DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_q0, r_q1, r_q2, r_q3;
  logic [7:0]  r_s1, r_t;
  logic        r_c1, r_c2;
  logic [15:0] r_product;
  logic        r_ovf, r_in_ready, r_out_valid;

  logic [7:0]  w_a, w_b, w_sum;
  logic        w_cout;

  always_comb begin
    w_a = r_q1;
    w_b = r_q2;
    case (r_state)
      S_ADD2:  begin w_a = r_s1; w_b = {4'b0, r_q0[7:4]}; end
      S_ADD3:  begin w_a = r_q3; w_b = {3'b0, r_c1 | r_c2, r_t[7:4]}; end
      default: begin w_a = r_q1; w_b = r_q2; end
    endcase
  end

  vedic_cla8 u_cla (
    .a    (w_a),
    .b    (w_b),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_q0        <= '0;
      r_q1        <= '0;
      r_q2        <= '0;
      r_q3        <= '0;
      r_s1        <= '0;
      r_t         <= '0;
      r_c1        <= 1'b0;
      r_c2        <= 1'b0;
      r_product   <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_q0       <= q0;
          r_q1       <= q1;
          r_q2       <= q2;
          r_q3       <= q3;
          r_in_ready <= 1'b0;
          r_state    <= S_ADD1;
        end
        S_ADD1: begin
          r_s1    <= w_sum;
          r_c1    <= w_cout;
          r_state <= S_ADD2;
        end
        S_ADD2: begin
          r_t            <= w_sum;
          r_c2           <= w_cout;
          r_product[7:0] <= {w_sum[3:0], r_q0[3:0]};
          r_state        <= S_ADD3;
        end
        S_ADD3: begin
          // A carry from both earlier adds cannot be folded into the single k bit.
          r_product[15:8] <= w_sum;
          r_ovf           <= w_cout | (r_c1 & r_c2);
          r_out_valid     <= 1'b1;
          r_state         <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_vedic_pp_accum.sv
// Directed bench for vedic_pp_accum: reset, arithmetic vectors, stall, throughput, reset abort.

module tb_vedic_pp_accum;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q0, q1, q2, q3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  vedic_pp_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one set for a single edge, scrambles the inputs while busy, and
  // returns the number of edges (capture edge included) until out_valid.
  task automatic send(input logic [7:0] a0, a1, a2, a3, output int lat);
    in_valid = 1'b1;
    q0 = a0; q1 = a1; q2 = a2; q3 = a3;
    step();
    in_valid = 1'b0;
    q0 = ~a0; q1 = ~a1; q2 = 8'h5A; q3 = 8'hA5;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    q0 = 8'h11; q1 = 8'h22; q2 = 8'h33; q3 = 8'h44;
    step(); step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", product); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_max();
    int lat;
    send(8'hE1, 8'hE1, 8'hE1, 8'hE1, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL max_latency got=%0d exp=4", lat); end
    checks++; if (product !== 16'hFE01) begin errors++; $display("FAIL max_product got=%h exp=fe01", product); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL max_ovf got=%b exp=0", ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL max_in_ready_done got=%b exp=0", in_ready); end
    release_out();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL max_back_idle got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid); end
  endtask

  task automatic test_mixed();
    int lat;
    send(8'h08, 8'h04, 8'h06, 8'h03, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL mixed_latency got=%0d exp=4", lat); end
    checks++; if (product !== 16'h03A8) begin errors++; $display("FAIL mixed_product got=%h exp=03a8", product); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mixed_ovf got=%b exp=0", ovf); end
    release_out();
  endtask

  task automatic test_ovf();
    int lat;
    send(8'hFF, 8'hFF, 8'hFF, 8'hFF, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_latency got=%0d exp=4", lat); end
    checks++; if (product !== 16'h0FDF) begin errors++; $display("FAIL ovf_product got=%h exp=0fdf", product); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    release_out();
  endtask

  task automatic test_stall();
    int lat;
    send(8'h08, 8'h04, 8'h06, 8'h03, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL stall_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 10; i++) begin
      q0 = 8'(i); q1 = 8'(i * 3);
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 16'h03A8 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got vld=%b rdy=%b prod=%h ovf=%b exp vld=1 rdy=0 prod=03a8 ovf=0",
                 i, out_valid, in_ready, product, ovf);
      end
    end
    release_out();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    int caps[$];
    int ncap;
    bit capt;
    q0 = 8'h00; q1 = 8'h00; q2 = 8'h00; q3 = 8'h00;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      capt = in_ready;
      step();
      if (capt) caps.push_back(cyc);
      if (in_ready && out_valid) begin
        checks++; errors++;
        $display("FAIL b2b_both_high cyc=%0d got rdy=1 vld=1 exp never both", cyc);
      end
      if (out_valid) begin
        checks++;
        if (product !== 16'h0000 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL b2b_zero_product got=%h ovf=%b exp=0000 ovf=0", product, ovf);
        end
      end
    end
    in_valid = 1'b0;
    ncap = caps.size();
    checks++;
    if (ncap < 3) begin
      errors++;
      $display("FAIL b2b_capture_count got=%0d exp>=3", ncap);
    end else begin
      checks++; if (caps[1] - caps[0] !== 5) begin errors++; $display("FAIL b2b_spacing1 got=%0d exp=5", caps[1] - caps[0]); end
      checks++; if (caps[2] - caps[1] !== 5) begin errors++; $display("FAIL b2b_spacing2 got=%0d exp=5", caps[2] - caps[1]); end
    end
    for (int i = 0; i < 10 && !in_ready; i++) step();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain got rdy=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    in_valid = 1'b1;
    q0 = 8'hE1; q1 = 8'hE1; q2 = 8'hE1; q3 = 8'hE1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL abort_product got=%h exp=0000", product); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_pulse got=%0d exp=0", seen); end
    send(8'h08, 8'h04, 8'h06, 8'h03, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL abort_recover_latency got=%0d exp=4", lat); end
    checks++; if (product !== 16'h03A8 || ovf !== 1'b0) begin errors++; $display("FAIL abort_recover_product got=%h ovf=%b exp=03a8 ovf=0", product, ovf); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_max();
    test_mixed();
    test_ovf();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
